sprite_line_fetch: RTL and testbench

Per-scanline sprite evaluator and loader feeding the 8-slot sprite shift chain. During horizontal blanking it scans the sprite attribute table in video RAM, selects up to 8 sprites that cover the next line, and fetches each sprite's 32-bit 2bpp pattern row. It then clears the chain and pushes one entry per `shift` strobe, which the per-sprite renderers and palettes consume on the following line.

---
 rtl/sprite_pkg.sv | 43 ++++
 rtl/sprite_hit_test.sv | 41 ++++
 rtl/sprite_line_fetch.sv | 215 +++++++++++++++++++++
 tb/tb_sprite_line_fetch.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the per-scanline sprite evaluator:
//   - attribute word field bit positions (word0 / word1)
//   - FSM state enumeration of sprite_line_fetch
//   - sprite height and per-line sprite limit
// Optional feature macro used by the block: SPRITE_VFLIP_EN (see sprite_hit_test).
// -----------------------------------------------------------------------------
package sprite_pkg;

  localparam int SPR_H        = 16;  // sprite height in lines
  localparam int MAX_PER_LINE = 8;   // slots in the sprite shift chain

  // posY value that marks an attribute entry as unused
  localparam logic [8:0] POSY_DISABLED = 9'h1FF;

  // word0 fields
  localparam int W0_POSX_LSB  = 0;   // [8:0]
  localparam int W0_POSY_LSB  = 9;   // [17:9]
  localparam int W0_VFLIP_BIT = 26;
  localparam int W0_SCLX_LSB  = 27;  // [30:27]
  localparam int W0_SWPX_BIT  = 31;

  // word1 fields
  localparam int W1_BC1_LSB   = 0;   // [4:0]
  localparam int W1_BC2_LSB   = 5;   // [9:5]
  localparam int W1_BC3_LSB   = 10;  // [14:10]
  localparam int W1_BC4_LSB   = 15;  // [19:15]
  localparam int W1_TILE_LSB  = 20;  // [29:20]

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CLR  = 4'd1,
    S_A0   = 4'd2,
    S_H0   = 4'd3,
    S_A1   = 4'd4,
    S_D1   = 4'd5,
    S_AP   = 4'd6,
    S_DP   = 4'd7,
    S_PUSH = 4'd8
  } state_t;

endpackage

// File: rtl/sprite_hit_test.sv
// -----------------------------------------------------------------------------
// sprite_hit_test
// Combinational vertical hit test for one attribute entry.
// Ports:
//   i_next_y [8:0] : line being prepared
//   i_pos_y  [8:0] : sprite top line (9'h1FF = disabled)
//   i_vflip        : vertical flip bit from word0
//   o_hit          : sprite covers i_next_y
//   o_row    [3:0] : pattern row to fetch
// Macro SPRITE_VFLIP_EN: when defined, i_vflip mirrors the row (15 - row);
// otherwise i_vflip is ignored.
// -----------------------------------------------------------------------------
module sprite_hit_test
  import sprite_pkg::*;
(
  input  logic [8:0] i_next_y,
  input  logic [8:0] i_pos_y,
  input  logic       i_vflip,
  output logic       o_hit,
  output logic [3:0] o_row
);

  logic [9:0] w_diff;

  // 10-bit difference; the >= test below rules out the wrapped case, so a
  // sprite starting near the bottom never wraps onto the top lines.
  assign w_diff = {1'b0, i_next_y} - {1'b0, i_pos_y};

  assign o_hit = (i_pos_y != POSY_DISABLED) &&
                 (i_next_y >= i_pos_y) &&
                 (w_diff < 10'(SPR_H));

`ifdef SPRITE_VFLIP_EN
  assign o_row = i_vflip ? (4'd15 - w_diff[3:0]) : w_diff[3:0];
`else
  logic w_unused_vflip;
  assign w_unused_vflip = i_vflip;
  assign o_row          = w_diff[3:0];
`endif

endmodule

// File: rtl/sprite_line_fetch.sv
// -----------------------------------------------------------------------------
// sprite_line_fetch
// Per-scanline sprite evaluator/loader. On i_line_start it clears the sprite
// shift chain, scans NUM_SPR attribute entries in video RAM, and for each of
// the first MAX_PER_LINE entries covering i_next_y fetches its pattern row
// and pushes one chain entry. A further hit sets o_overflow and ends the scan.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_line_start          : hblank pulse, starts (or restarts) a scan
//   i_next_y   [8:0]      : line being prepared, sampled on i_line_start
//   i_fromRAM  [31:0]     : RAM read data, valid one cycle after o_addr
//   o_addr     [15:0]     : RAM word address
//   o_clr, o_shift        : chain clear / push strobes (never together)
//   o_posX, o_sclX, o_swpX, o_bcolor1..4, o_colors : pushed entry fields,
//                           valid with o_shift and held until the next push
//   o_busy                : scan in progress
//   o_overflow            : more than MAX_PER_LINE hits on this line
//   o_state               : FSM state (debug)
// Macro SPRITE_VFLIP_EN enables vertical flip (word0 bit 26).
// Handshake: no back-pressure. o_clr/o_shift are single-cycle strobes the
// chain must accept in the cycle they are high; RAM answers every address
// one cycle later.
// -----------------------------------------------------------------------------
module sprite_line_fetch
  import sprite_pkg::*;
#(
  parameter int          NUM_SPR   = 64,
  parameter logic [15:0] ATTR_BASE = 16'h7E00,
  parameter logic [15:0] PAT_BASE  = 16'h4000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_line_start,
  input  logic [8:0]  i_next_y,
  input  logic [31:0] i_fromRAM,
  output logic [15:0] o_addr,
  output logic        o_clr,
  output logic        o_shift,
  output logic [8:0]  o_posX,
  output logic [3:0]  o_sclX,
  output logic        o_swpX,
  output logic [4:0]  o_bcolor1,
  output logic [4:0]  o_bcolor2,
  output logic [4:0]  o_bcolor3,
  output logic [4:0]  o_bcolor4,
  output logic [31:0] o_colors,
  output logic        o_busy,
  output logic        o_overflow,
  output state_t      o_state
);

  localparam int IDX_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [3:0]         r_count;
  logic [8:0]         r_next_y;
  logic [3:0]         r_row;
  logic [8:0]         r_posx;
  logic [3:0]         r_sclx;
  logic               r_swpx;
  logic [19:0]        r_bc;
  logic [15:0]        r_addr;
  logic               r_clr;
  logic               r_shift;
  logic [8:0]         r_o_posx;
  logic [3:0]         r_o_sclx;
  logic               r_o_swpx;
  logic [19:0]        r_o_bc;
  logic [31:0]        r_o_colors;
  logic               r_busy;
  logic               r_overflow;

  logic               w_hit;
  logic [3:0]         w_row;
  logic               w_last_idx;
  logic [IDX_W-1:0]   w_idx_inc;
  logic [15:0]        w_addr_w0_next;
  logic [15:0]        w_addr_w1;
  logic [15:0]        w_addr_pat;

  // Word0 arrives on i_fromRAM during H0, so the hit test reads it directly.
  sprite_hit_test u_hit (
    .i_next_y (r_next_y),
    .i_pos_y  (i_fromRAM[W0_POSY_LSB +: 9]),
    .i_vflip  (i_fromRAM[W0_VFLIP_BIT]),
    .o_hit    (w_hit),
    .o_row    (w_row)
  );

  assign w_last_idx     = (r_idx == IDX_W'(NUM_SPR - 1));
  assign w_idx_inc      = r_idx + IDX_W'(1);
  assign w_addr_w0_next = ATTR_BASE + 16'({w_idx_inc, 1'b0});
  assign w_addr_w1      = ATTR_BASE + 16'({r_idx, 1'b1});
  // Tile arrives during D1; {tile,row} is 14 bits, carry past bit 15 dropped.
  assign w_addr_pat     = PAT_BASE + 16'({i_fromRAM[W1_TILE_LSB +: 10], r_row});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_count    <= '0;
      r_next_y   <= '0;
      r_row      <= '0;
      r_posx     <= '0;
      r_sclx     <= '0;
      r_swpx     <= 1'b0;
      r_bc       <= '0;
      r_addr     <= '0;
      r_clr      <= 1'b0;
      r_shift    <= 1'b0;
      r_o_posx   <= '0;
      r_o_sclx   <= '0;
      r_o_swpx   <= 1'b0;
      r_o_bc     <= '0;
      r_o_colors <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_clr   <= 1'b0;
      r_shift <= 1'b0;
      if (i_line_start) begin
        // Start, or abort a scan in flight; the new clear discards the chain.
        r_state    <= S_CLR;
        r_clr      <= 1'b1;
        r_busy     <= 1'b1;
        r_overflow <= 1'b0;
        r_count    <= '0;
        r_idx      <= '0;
        r_next_y   <= i_next_y;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_CLR: begin
            r_idx   <= '0;
            r_addr  <= ATTR_BASE;
            r_state <= S_A0;
          end
          S_A0: r_state <= S_H0;
          S_H0: begin
            r_posx <= i_fromRAM[W0_POSX_LSB +: 9];
            r_sclx <= i_fromRAM[W0_SCLX_LSB +: 4];
            r_swpx <= i_fromRAM[W0_SWPX_BIT];
            r_row  <= w_row;
            if (!w_hit) begin
              if (w_last_idx) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_idx   <= w_idx_inc;
                r_addr  <= w_addr_w0_next;
                r_state <= S_A0;
              end
            end else if (r_count == 4'(MAX_PER_LINE)) begin
              r_overflow <= 1'b1;
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_addr  <= w_addr_w1;
              r_state <= S_A1;
            end
          end
          S_A1: r_state <= S_D1;
          S_D1: begin
            r_bc    <= i_fromRAM[19:0];
            r_addr  <= w_addr_pat;
            r_state <= S_AP;
          end
          S_AP: r_state <= S_DP;
          S_DP: begin
            // All pushed fields update together so they are valid with shift.
            r_o_posx   <= r_posx;
            r_o_sclx   <= r_sclx;
            r_o_swpx   <= r_swpx;
            r_o_bc     <= r_bc;
            r_o_colors <= i_fromRAM;
            r_shift    <= 1'b1;
            r_state    <= S_PUSH;
          end
          S_PUSH: begin
            r_count <= r_count + 4'd1;
            if (w_last_idx) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_idx   <= w_idx_inc;
              r_addr  <= w_addr_w0_next;
              r_state <= S_A0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_addr     = r_addr;
  assign o_clr      = r_clr;
  assign o_shift    = r_shift;
  assign o_posX     = r_o_posx;
  assign o_sclX     = r_o_sclx;
  assign o_swpX     = r_o_swpx;
  assign o_bcolor1  = r_o_bc[W1_BC1_LSB +: 5];
  assign o_bcolor2  = r_o_bc[W1_BC2_LSB +: 5];
  assign o_bcolor3  = r_o_bc[W1_BC3_LSB +: 5];
  assign o_bcolor4  = r_o_bc[W1_BC4_LSB +: 5];
  assign o_colors   = r_o_colors;
  assign o_busy     = r_busy;
  assign o_overflow = r_overflow;
  assign o_state    = r_state;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// -----------------------------------------------------------------------------
// tb_sprite_line_fetch
// Directed bench for sprite_line_fetch with a behavioural 64K x 32 video RAM.
// Pattern RAM words are {~addr, addr} so every pushed colour word identifies
// the address it was fetched from.
// -----------------------------------------------------------------------------
module tb_sprite_line_fetch;
  import sprite_pkg::*;

  localparam logic [15:0] ATTR = 16'h7E00;
  localparam logic [15:0] PAT  = 16'h4000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        line_start;
  logic [8:0]  next_y;
  logic [31:0] from_ram;
  logic [15:0] o_addr;
  logic        o_clr, o_shift, o_swpX, o_busy, o_overflow;
  logic [8:0]  o_posX;
  logic [3:0]  o_sclX;
  logic [4:0]  o_bcolor1, o_bcolor2, o_bcolor3, o_bcolor4;
  logic [31:0] o_colors;
  state_t      o_state;

  sprite_line_fetch dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_line_start (line_start),
    .i_next_y     (next_y),
    .i_fromRAM    (from_ram),
    .o_addr       (o_addr),
    .o_clr        (o_clr),
    .o_shift      (o_shift),
    .o_posX       (o_posX),
    .o_sclX       (o_sclX),
    .o_swpX       (o_swpX),
    .o_bcolor1    (o_bcolor1),
    .o_bcolor2    (o_bcolor2),
    .o_bcolor3    (o_bcolor3),
    .o_bcolor4    (o_bcolor4),
    .o_colors     (o_colors),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow),
    .o_state      (o_state)
  );

  // ---------------- RAM model ----------------
  logic [31:0] mem [0:65535];
  always @(posedge clk) from_ram <= mem[o_addr];

  function automatic logic [31:0] pat_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  // ---------------- scoreboard ----------------
  logic [65:0] exp_q[$];
  logic [65:0] act_q[$];
  logic [15:0] addr_log[$];
  int clr_cnt, busy_cnt, both_cnt;
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (o_clr) clr_cnt++;
    if (o_shift) act_q.push_back({o_posX, o_sclX, o_swpX,
                                  o_bcolor4, o_bcolor3, o_bcolor2, o_bcolor1, o_colors});
    if (o_clr && o_shift) both_cnt++;
    if (o_busy) busy_cnt++;
    if (o_state == S_A0 || o_state == S_A1 || o_state == S_AP) addr_log.push_back(o_addr);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_table();
    for (int i = 0; i < 64; i++) begin
      mem[ATTR + 16'(2*i)]     = {14'd0, 9'h1FF, 9'd0};
      mem[ATTR + 16'(2*i + 1)] = 32'd0;
    end
  endtask

  task automatic set_entry(input int idx, input logic [8:0] posx, input logic [8:0] posy,
                           input logic [3:0] sclx, input logic swpx, input logic vflip,
                           input logic [19:0] bc, input logic [9:0] tile);
    mem[ATTR + 16'(2*idx)]     = {swpx, sclx, vflip, 8'd0, posy, posx};
    mem[ATTR + 16'(2*idx + 1)] = {2'b00, tile, bc};
  endtask

  function automatic logic [65:0] exp_push(input logic [8:0] posx, input logic [8:0] posy,
                                           input logic [3:0] sclx, input logic swpx,
                                           input logic vflip, input logic [19:0] bc,
                                           input logic [9:0] tile, input logic [8:0] y);
    logic [8:0]  d;
    logic [3:0]  row;
    logic [15:0] pa;
    d   = y - posy;
    row = d[3:0];
`ifdef SPRITE_VFLIP_EN
    if (vflip) row = 4'd15 - row;
`else
    if (vflip) row = row;
`endif
    pa = PAT + 16'({tile, row});
    return {posx, sclx, swpx, bc, pat_word(pa)};
  endfunction

  // Pulse line_start for one cycle; logs restart once the pulse is sampled.
  task automatic pulse(input logic [8:0] y);
    @(posedge clk); #1;
    line_start = 1'b1;
    next_y     = y;
    @(posedge clk); #1;
    line_start = 1'b0;
    clr_cnt  = 0;
    busy_cnt = 0;
    act_q.delete();
    addr_log.delete();
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!o_busy) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic run_line(input string tag, input logic [8:0] y);
    pulse(y);
    wait_idle(tag);
  endtask

  task automatic compare_pushes(input string tag);
    int n;
    check({tag, "_npush"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_push%0d", tag, i), act_q[i], exp_q[i]);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    rst        = 1'b1;
    line_start = 1'b0;
    next_y     = '0;
    for (int a = 0; a < 65536; a++) mem[a] = pat_word(16'(a));
    clear_table();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr",  o_addr, 16'h0);
    check("rst_clr",   o_clr, 1'b0);
    check("rst_shift", o_shift, 1'b0);
    check("rst_busy",  o_busy, 1'b0);
    check("rst_ovf",   o_overflow, 1'b0);
    check("rst_flds",  {o_posX, o_sclX, o_swpX, o_bcolor1, o_bcolor2, o_bcolor3,
                        o_bcolor4, o_colors}, 66'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single sprite: entry 3, posY 100, posX 40, tile 5, line 105 -> row 5.
    set_entry(3, 9'd40, 9'd100, 4'd3, 1'b1, 1'b0, 20'h12345, 10'd5);
    exp_q.push_back({9'd40, 4'd3, 1'b1, 20'h12345, 32'hBFAA_4055});
    run_line("one", 9'd105);
    check("one_clr", clr_cnt, 1);
    compare_pushes("one");
    check("one_a3", addr_log[3], 16'h7E06);
    check("one_a4", addr_log[4], 16'h7E07);
    check("one_a5", addr_log[5], 16'h4055);
    check("one_posx_held", o_posX, 9'd40);
    check("one_colors_held", o_colors, 32'hBFAA_4055);
    check("one_busy_cyc", busy_cnt, 134);
    check("one_ovf", o_overflow, 1'b0);

    // Ten hits on line 50: first eight pushed, overflow at index 8.
    clear_table();
    for (int i = 0; i < 10; i++)
      set_entry(i, 9'(10*i), 9'(40+i), 4'(i), 1'(i), 1'b0, 20'(i*3), 10'(i+1));
    for (int i = 0; i < 8; i++)
      exp_q.push_back(exp_push(9'(10*i), 9'(40+i), 4'(i), 1'(i), 1'b0, 20'(i*3),
                               10'(i+1), 9'd50));
    run_line("ovf", 9'd50);
    check("ovf_clr", clr_cnt, 1);
    compare_pushes("ovf");
    check("ovf_flag", o_overflow, 1'b1);
    check("ovf_nlog", addr_log.size(), 25);
    check("ovf_last_addr", addr_log[addr_log.size()-1], 16'h7E10);
    check("ovf_busy_cyc", busy_cnt, 59);

    // Restart 20 cycles into a scan: new clear, scan from index 0.
    pulse(9'd50);
    repeat (20) @(negedge clk);
    check("rp_busy_mid", o_busy, 1'b1);
    check("rp_ovf_mid", o_overflow, 1'b0);
    for (int i = 0; i < 8; i++)
      exp_q.push_back(exp_push(9'(10*i), 9'(40+i), 4'(i), 1'(i), 1'b0, 20'(i*3),
                               10'(i+1), 9'd50));
    run_line("rp", 9'd50);
    check("rp_clr", clr_cnt, 1);
    check("rp_first_addr", addr_log[0], 16'h7E00);
    compare_pushes("rp");
    check("rp_ovf", o_overflow, 1'b1);

    // Boundaries: disabled posY, line above / below a sprite, last row.
    clear_table();
    set_entry(0, 9'd7, 9'h1FF, 4'd0, 1'b0, 1'b0, 20'h0, 10'd3);
    run_line("dis", 9'd511);
    check("dis_clr", clr_cnt, 1);
    check("dis_npush", act_q.size(), 0);
    check("dis_ovf_clr", o_overflow, 1'b0);
    set_entry(1, 9'd9, 9'd200, 4'd1, 1'b0, 1'b0, 20'hABCDE, 10'h012);
    run_line("above", 9'd199);
    check("above_npush", act_q.size(), 0);
    run_line("below", 9'd216);
    check("below_npush", act_q.size(), 0);
    exp_q.push_back({9'd9, 4'd1, 1'b0, 20'hABCDE, pat_word(16'h412F)});
    run_line("last", 9'd215);
    compare_pushes("last");
    check("last_pat_addr", addr_log[3], 16'h412F);

    // Vertical flip: row 2 becomes row 13 only when the feature is built in.
    clear_table();
    set_entry(2, 9'd1, 9'd10, 4'd0, 1'b0, 1'b1, 20'h0, 10'd9);
    run_line("vf", 9'd12);
    check("vf_npush", act_q.size(), 1);
`ifdef SPRITE_VFLIP_EN
    check("vf_pat_addr", addr_log[4], 16'h409D);
`else
    check("vf_pat_addr", addr_log[4], 16'h4092);
`endif

    // Reset during PUSH, then a normal line.
    clear_table();
    set_entry(3, 9'd40, 9'd100, 4'd3, 1'b1, 1'b0, 20'h12345, 10'd5);
    pulse(9'd105);
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (o_shift) begin
        found = 1'b1;
        break;
      end
    end
    check("rr_found_push", found, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rr_busy", o_busy, 1'b0);
    check("rr_shift", o_shift, 1'b0);
    check("rr_state", o_state, S_IDLE);
    check("rr_outs", {o_addr, o_clr, o_overflow, o_posX, o_sclX, o_swpX, o_bcolor1,
                      o_bcolor2, o_bcolor3, o_bcolor4, o_colors}, 66'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back({9'd40, 4'd3, 1'b1, 20'h12345, 32'hBFAA_4055});
    run_line("rr", 9'd105);
    check("rr_clr", clr_cnt, 1);
    compare_pushes("rr");

    check("clr_shift_overlap", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
